// File: rtl/imem_loader_pkg.sv
// Shared types for the UART instruction-memory boot loader:
// loader and receiver state encodings plus the image header size.
package imem_loader_pkg;

  localparam int HDR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    DONE,
    WAIT
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with its own input synchronizer; reports each
// byte with a one-cycle rx_valid, or rx_ferr when the stop bit is low.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic [7:0] rx_data
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

  rx_state_t     state, next_state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tick_half, tick_full;

  assign tick_half = (timer == HALF);
  assign tick_full = (timer == FULL);
  assign rx_data   = shift;

  // The line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) next_state = RX_START;
      RX_START: if (tick_half) next_state = rx_sync ? RX_IDLE : RX_BITS;
      RX_BITS:  if (tick_full && bit_idx == 3'd7) next_state = RX_STOP;
      RX_STOP:  if (tick_full) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_valid = (state == RX_STOP) && tick_full && rx_sync;
    rx_ferr  = (state == RX_STOP) && tick_full && !rx_sync;
  end

  // Timer restarts at the mid-start check so every later sample lands mid-bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state == RX_IDLE || (state == RX_START && tick_half) || tick_full)
        timer <= '0;
      else
        timer <= timer + TW'(1);

      if (state == RX_START)
        bit_idx <= '0;
      else if (state == RX_BITS && tick_full)
        bit_idx <= bit_idx + 3'd1;

      if (state == RX_BITS && tick_full)
        shift <= {rx_sync, shift[7:1]};
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed image over UART and writes it
// byte-lane by byte-lane into instruction RAM while the core is held.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_AW      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_imem,
  input  logic               uart0_rxd,
  output logic               imem_we,
  output logic [IMEM_AW-3:0] imem_addr,
  output logic [3:0]         imem_byteen,
  output logic [31:0]        imem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               load_done,
  output logic               load_err
);

  localparam logic [31:0] IMEM_BYTES = 32'd1 << IMEM_AW;

  loader_state_t state, next_state;
  logic          load_meta, load_s;
  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_data;
  logic [31:0]   len, len_next, byte_cnt;
  logic [2:0]    hdr_cnt;
  logic          last_hdr, last_byte;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .rxd     (uart0_rxd),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr),
    .rx_data (rx_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_meta <= 1'b0;
      load_s    <= 1'b0;
    end else begin
      load_meta <= load_imem;
      load_s    <= load_meta;
    end
  end

  assign len_next  = {rx_data, len[31:8]};
  assign last_hdr  = (hdr_cnt == 3'(HDR_BYTES - 1));
  assign last_byte = (byte_cnt == len - 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Dropping the strap always beats a byte arriving in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (load_s) next_state = LEN;
      LEN: begin
        if (!load_s)                   next_state = IDLE;
        else if (rx_ferr)              next_state = WAIT;
        else if (rx_valid && last_hdr) next_state = (len_next == 32'd0) ? DONE : DATA;
      end
      DATA: begin
        if (!load_s)                    next_state = IDLE;
        else if (rx_ferr)               next_state = WAIT;
        else if (rx_valid && last_byte) next_state = DONE;
      end
      DONE:    next_state = WAIT;
      WAIT:    if (!load_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    cpu_hold = (state != IDLE) | load_s;
  end

  // Bytes past the end of imem are still counted so the transfer completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_byteen <= '0;
      imem_wdata  <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      len         <= '0;
      byte_cnt    <= '0;
      hdr_cnt     <= '0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (load_s) begin
            byte_cnt <= '0;
            len      <= '0;
            hdr_cnt  <= '0;
            load_err <= 1'b0;
          end
        end
        LEN: begin
          if (!load_s || rx_ferr) begin
            load_err <= 1'b1;
          end else if (rx_valid) begin
            len     <= len_next;
            hdr_cnt <= hdr_cnt + 3'd1;
            if (last_hdr && len_next > IMEM_BYTES) load_err <= 1'b1;
          end
        end
        DATA: begin
          if (!load_s || rx_ferr) begin
            load_err <= 1'b1;
          end else if (rx_valid) begin
            byte_cnt <= byte_cnt + 32'd1;
            if (byte_cnt < IMEM_BYTES) begin
              imem_we     <= 1'b1;
              imem_addr   <= byte_cnt[IMEM_AW-1:2];
              imem_byteen <= 4'b0001 << byte_cnt[1:0];
              imem_wdata  <= {4{rx_data}};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: serial image loads, zero length,
// framing error, abort, overflow, start-bit glitch and mid-load reset.
module tb_imem_uart_loader;
  import imem_loader_pkg::*;

  localparam int CPB = 16;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_imem;
  logic          uart0_rxd;
  logic          imem_we;
  logic [AW-3:0] imem_addr;
  logic [3:0]    imem_byteen;
  logic [31:0]   imem_wdata;
  logic          cpu_hold, busy, load_done, load_err;

  int n_vec = 0;
  int n_err = 0;

  int            wr_count = 0;
  int            done_count = 0;
  int            rxv_count = 0;
  logic [AW-3:0] log_addr [0:1023];
  logic [3:0]    log_be   [0:1023];
  logic [31:0]   log_data [0:1023];

  typedef struct {
    logic [7:0]    data;
    logic          exp_we;
    logic [AW-3:0] exp_addr;
    logic [3:0]    exp_be;
    logic [31:0]   exp_wdata;
  } vec_t;

  vec_t vecs [9];

  imem_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .IMEM_AW     (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_imem  (load_imem),
    .uart0_rxd  (uart0_rxd),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_byteen(imem_byteen),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Log every write port transaction and completion pulse on the quiet edge.
  always @(negedge clk) begin
    if (imem_we) begin
      log_addr[wr_count] <= imem_addr;
      log_be[wr_count]   <= imem_byteen;
      log_data[wr_count] <= imem_wdata;
      wr_count           <= wr_count + 1;
    end
    if (load_done) done_count <= done_count + 1;
    if (dut.rx_valid) rxv_count <= rxv_count + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
    uart0_rxd = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart0_rxd = b[i];
      wait_clks(CPB);
    end
    uart0_rxd = stop_bit;
    wait_clks(CPB);
    uart0_rxd = 1'b1;
    wait_clks(CPB);
  endtask

  initial begin
    int base_wr, base_done, base_rxv;

    vecs[0] = '{8'h05, 1'b0, 6'd0, 4'b0000, 32'h0};
    vecs[1] = '{8'h00, 1'b0, 6'd0, 4'b0000, 32'h0};
    vecs[2] = '{8'h00, 1'b0, 6'd0, 4'b0000, 32'h0};
    vecs[3] = '{8'h00, 1'b0, 6'd0, 4'b0000, 32'h0};
    vecs[4] = '{8'h11, 1'b1, 6'd0, 4'b0001, 32'h11111111};
    vecs[5] = '{8'h22, 1'b1, 6'd0, 4'b0010, 32'h22222222};
    vecs[6] = '{8'h33, 1'b1, 6'd0, 4'b0100, 32'h33333333};
    vecs[7] = '{8'h44, 1'b1, 6'd0, 4'b1000, 32'h44444444};
    vecs[8] = '{8'h55, 1'b1, 6'd1, 4'b0001, 32'h55555555};

    reset     = 1'b0;
    load_imem = 1'b0;
    uart0_rxd = 1'b1;
    wait_clks(3);
    check_output("rst_we",      32'(imem_we),     32'd0);
    check_output("rst_addr",    32'(imem_addr),   32'd0);
    check_output("rst_byteen",  32'(imem_byteen), 32'd0);
    check_output("rst_wdata",   imem_wdata,       32'd0);
    check_output("rst_hold",    32'(cpu_hold),    32'd0);
    check_output("rst_busy",    32'(busy),        32'd0);
    check_output("rst_done",    32'(load_done),   32'd0);
    check_output("rst_err",     32'(load_err),    32'd0);
    reset = 1'b1;
    wait_clks(10);
    check_output("idle_hold",   32'(cpu_hold),    32'd0);
    check_output("idle_busy",   32'(busy),        32'd0);

    // Normal load driven from the vector table.
    load_imem = 1'b1;
    wait_clks(1);
    check_output("hold_not_yet", 32'(cpu_hold), 32'd0);
    wait_clks(3);
    check_output("hold_rise", 32'(cpu_hold), 32'd1);
    base_done = done_count;
    for (int v = 0; v < 9; v++) begin
      base_wr = wr_count;
      apply_stimulus(vecs[v].data, 1'b1);
      check_output($sformatf("v%0d_nwr", v), 32'(wr_count - base_wr), 32'(vecs[v].exp_we));
      if (vecs[v].exp_we && wr_count > base_wr) begin
        check_output($sformatf("v%0d_addr", v), 32'(log_addr[base_wr]), 32'(vecs[v].exp_addr));
        check_output($sformatf("v%0d_be", v),   32'(log_be[base_wr]),   32'(vecs[v].exp_be));
        check_output($sformatf("v%0d_data", v), log_data[base_wr],      vecs[v].exp_wdata);
      end
    end
    wait_clks(4);
    check_output("norm_done", 32'(done_count - base_done), 32'd1);
    check_output("norm_err",  32'(load_err), 32'd0);
    check_output("norm_hold", 32'(cpu_hold), 32'd1);
    check_output("norm_wait", 32'(dut.state), 32'(WAIT));
    load_imem = 1'b0;
    wait_clks(5);
    check_output("norm_release", 32'(cpu_hold), 32'd0);
    check_output("norm_idle",    32'(busy),     32'd0);

    // Zero-length image.
    load_imem = 1'b1;
    wait_clks(4);
    base_wr = wr_count;
    base_done = done_count;
    for (int i = 0; i < 4; i++) apply_stimulus(8'h00, 1'b1);
    wait_clks(4);
    check_output("zero_nwr",  32'(wr_count - base_wr), 32'd0);
    check_output("zero_done", 32'(done_count - base_done), 32'd1);
    check_output("zero_err",  32'(load_err), 32'd0);
    load_imem = 1'b0;
    wait_clks(5);

    // Framing error on the third payload byte.
    load_imem = 1'b1;
    wait_clks(4);
    base_wr = wr_count;
    base_done = done_count;
    apply_stimulus(8'h03, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'hAA, 1'b1);
    apply_stimulus(8'hBB, 1'b1);
    apply_stimulus(8'hCC, 1'b0);
    wait_clks(4);
    check_output("ferr_nwr",   32'(wr_count - base_wr), 32'd2);
    check_output("ferr_err",   32'(load_err), 32'd1);
    check_output("ferr_done",  32'(done_count - base_done), 32'd0);
    check_output("ferr_state", 32'(dut.state), 32'(WAIT));
    load_imem = 1'b0;
    wait_clks(5);

    // Abort after two payload bytes of an eight byte image.
    load_imem = 1'b1;
    wait_clks(4);
    base_wr = wr_count;
    apply_stimulus(8'h08, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'h01, 1'b1);
    apply_stimulus(8'h02, 1'b1);
    load_imem = 1'b0;
    wait_clks(4);
    check_output("abort_err",   32'(load_err), 32'd1);
    check_output("abort_state", 32'(dut.state), 32'(IDLE));
    apply_stimulus(8'h03, 1'b1);
    wait_clks(4);
    check_output("abort_nwr", 32'(wr_count - base_wr), 32'd2);
    load_imem = 1'b1;
    wait_clks(4);
    check_output("reload_err_clr", 32'(load_err), 32'd0);
    check_output("reload_state",   32'(dut.state), 32'(LEN));

    // Overflow: N = 0x104 into a 256-byte imem, continuing the fresh LEN.
    base_wr = wr_count;
    base_done = done_count;
    apply_stimulus(8'h04, 1'b1);
    apply_stimulus(8'h01, 1'b1);
    apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'h00, 1'b1);
    check_output("ovf_err_hdr", 32'(load_err), 32'd1);
    for (int k = 0; k < 260; k++) apply_stimulus(8'(k), 1'b1);
    wait_clks(4);
    check_output("ovf_nwr",  32'(wr_count - base_wr), 32'd256);
    check_output("ovf_done", 32'(done_count - base_done), 32'd1);
    check_output("ovf_err",  32'(load_err), 32'd1);
    check_output("ovf_last_addr", 32'(log_addr[base_wr + 255]), 32'd63);
    check_output("ovf_last_be",   32'(log_be[base_wr + 255]),   32'b1000);
    check_output("ovf_last_data", log_data[base_wr + 255],      32'hFFFFFFFF);
    check_output("ovf_mid_data",  log_data[base_wr + 130],      32'h82828282);
    load_imem = 1'b0;
    wait_clks(5);

    // Start-bit glitch while collecting the header.
    load_imem = 1'b1;
    wait_clks(4);
    base_rxv = rxv_count;
    uart0_rxd = 1'b0;
    wait_clks(3);
    uart0_rxd = 1'b1;
    wait_clks(12 * CPB);
    check_output("glitch_rxv",   32'(rxv_count - base_rxv), 32'd0);
    check_output("glitch_state", 32'(dut.state), 32'(LEN));
    check_output("glitch_hdr",   32'(dut.hdr_cnt), 32'd0);

    // Reset in the middle of a load drops the hold at once.
    apply_stimulus(8'h01, 1'b1);
    reset = 1'b0;
    #1;
    check_output("midrst_hold", 32'(cpu_hold), 32'd0);
    check_output("midrst_we",   32'(imem_we),  32'd0);
    load_imem = 1'b0;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(4);
    check_output("midrst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

UART boot loader that writes a program image into the SoC instruction RAM while the core is held in reset. It is enabled by the board-level `load_imem` strap. Serial bytes arrive on `uart0_rxd` and are written one byte lane at a time into the imem byte-lane write port. When the image is complete, the core is released.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clocks per UART bit (100 MHz / 115200); minimum 8.
- `IMEM_AW`, 16: imem byte-address width; capacity is 2^IMEM_AW bytes.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `load_imem` in 1: level request to load; asynchronous to `clk`.
- `uart0_rxd` in 1: UART RX, 8N1, LSB first, idles high; asynchronous.
- `imem_we` out 1: imem write strobe, one cycle per byte.
- `imem_addr` out IMEM_AW-2: imem word address.
- `imem_byteen` out 4: one-hot byte-lane enable (lane0 = bits 7:0).
- `imem_wdata` out 32: received byte replicated on all four lanes.
- `cpu_hold` out 1: holds the core in reset while loading.
- `busy` out 1: FSM is not in IDLE.
- `load_done` out 1: one-cycle pulse on successful completion.
- `load_err` out 1: sticky error flag; cleared on the next IDLE→LEN entry or by reset.

## Operation
Input synchronization:
- `load_imem` and `uart0_rxd` each pass through 2-FF synchronizers.
- The synchronizers reset to 0 and 1 respectively.

Byte receiver:
- Detects a falling edge while idle.
- Re-checks low at CLKS_PER_BIT/2; if high, treats it as a glitch and returns to idle.
- Samples 8 data bits, then the stop bit, each CLKS_PER_BIT later.
- Emits `rx_valid` for one cycle at the stop-bit sample.
- Stop bit = 0 raises `rx_ferr` instead; the byte is discarded.

Image format:
- 4-byte little-endian length N, then N payload bytes.
- Payload byte k goes to byte address k.

Loader FSM (states in package):
- IDLE: wait for synchronized `load_imem`=1. Then clear `byte_cnt`, `len`, `hdr_cnt` and `load_err`, and go to LEN.
- LEN: shift 4 bytes into `len[31:0]`, LSB first.
  - After the 4th byte: if N==0 go to DONE, else go to DATA.
- DATA: on each `rx_valid`, issue a write at `byte_cnt` and increment `byte_cnt`.
  - When `byte_cnt` reaches N-1 and is written, go to DONE.
- DONE: pulse `load_done` for one cycle, then go to WAIT.
- WAIT: stay until `load_imem`=0, then go to IDLE. This prevents reloading from a held strap.

Write format:
- `imem_addr` = `byte_cnt[IMEM_AW-1:2]`.
- `imem_byteen` = 1 << `byte_cnt[1:0]`.
- `imem_wdata` = {4{byte}}.

Errors:
- `rx_ferr` in LEN or DATA: set `load_err`, go to WAIT.
- N > 2^IMEM_AW: set `load_err`. The excess bytes are received and counted but not written (`imem_we` stays 0), and the transfer still ends in DONE.
- `load_imem` drops while in LEN or DATA: abort. Set `load_err`, go to IDLE, issue no further writes.

Output rules:
- `cpu_hold` = (state != IDLE) | synchronized `load_imem`.
- `busy` = (state != IDLE).
- Write outputs are registered.

## Timing
Reset values:
- All outputs are 0.
- FSM is in IDLE; all counters are 0.

Latency:
- Serial line to the receiver: 2 clk synchronizer delay.
- `rx_valid` fires about 9.5·CLKS_PER_BIT after the start edge plus 2 clk.
- `imem_we` is asserted exactly 1 cycle after `rx_valid`, for 1 cycle.
- `load_done` is asserted 1 cycle after the last write.
- `cpu_hold` rises 2 clk after `load_imem` rises. It falls on the first cycle back in IDLE with `load_imem` low.

Boundary and simultaneous events:
- Bytes arrive at most once per 10·CLKS_PER_BIT, so no buffering is required.
- An `rx_valid` in IDLE, DONE or WAIT is ignored.
- `rx_valid` in the same cycle as `load_imem` falling: the abort wins and no write is issued.
- `byte_cnt` is 32 bits and does not wrap within a legal N.
- Reset asserted mid-load immediately drops `imem_we` and `cpu_hold`.

## Structure
- Package `imem_loader_pkg`: FSM state enum (IDLE, LEN, DATA, DONE, WAIT) and the header length constant HDR_BYTES = 4.
- Sub-module `uart_rx_byte`, parameterized by CLKS_PER_BIT. It owns the RX synchronizer, bit timer, shift register, `rx_valid` and `rx_ferr`. It is reusable by the SoC UART peripheral.
- The top level holds the loader FSM, counters and write-port registers.

## Test plan
All scenarios use CLKS_PER_BIT=16 and IMEM_AW=8.
- Reset: with `reset`=0, all outputs are 0. Release reset with `load_imem`=0: no activity and `cpu_hold` stays 0.
- Normal load: assert `load_imem`, send 05 00 00 00 11 22 33 44 55.
  - Required writes: addr0/be0001/0x11111111, addr0/be0010, addr0/be0100, addr0/be1000, then addr1/be0001/0x55555555.
  - Then one `load_done` pulse. `cpu_hold` drops only after `load_imem` is released.
- Zero length: send 00 00 00 00. Required: no `imem_we`, `load_done` pulses, `load_err`=0.
- Framing error: a stop bit of 0 on the 3rd payload byte. Required: 2 writes only, `load_err`=1, no `load_done`, FSM in WAIT.
- Abort: deassert `load_imem` after 2 payload bytes of N=8. Required: writes stop, `load_err`=1, FSM in IDLE. A new `load_imem` clears `load_err`.
- Overflow: N=0x104 with IMEM_AW=8. Required: 256 writes, 4 suppressed bytes, `load_err`=1, `load_done` pulses.
- Glitch: a 3-clk low pulse on RX. Required: no byte is received and no state change.
